// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   FETCH_WIDTH / FETCH_INSTR_WIDTH / FETCH_DEPTH : default geometry
//   CNT_W         : width of a counter that can hold 0..FETCH_DEPTH
//   fetch_entry_t : one buffered instruction tagged with its PC
package fetch_pkg;

    localparam int unsigned FETCH_WIDTH       = 32;
    localparam int unsigned FETCH_INSTR_WIDTH = 32;
    localparam int unsigned FETCH_DEPTH       = 2;
    localparam int unsigned CNT_W             = $clog2(FETCH_DEPTH + 1);

    typedef struct packed {
        logic [FETCH_WIDTH-1:0]       pc;
        logic [FETCH_INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO used for both the address-tag queue and the instruction queue.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   flush_i         : empties the FIFO; wins over a same-cycle push/pop
//   push_i, data_i  : write port (ignored when full)
//   pop_i, data_o   : read port; data_o is the head entry (ignored when empty)
//   full_o, empty_o : status
//   count_o         : number of stored entries, 0..DEPTH
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CW-1:0]     count_q;
    logic              push_ok;
    logic              pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem[rd_ptr];

    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage needs no reset: an entry is only observed after it is written.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage between the program counter and decode.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   pc_i, pc_advance_o     : current PC in; increment enable out (one per accepted request)
//   redirect_i             : flush, asserted in the cycle the PC jumps
//   imem_req_*             : in-order request channel to instruction memory
//   imem_rsp_*             : in-order response channel, no backpressure
//   instr_valid_o/ready_i  : handshake to decode; instr_o / instr_pc_o are the queue head
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH       = FETCH_WIDTH,
    parameter int unsigned INSTR_WIDTH = FETCH_INSTR_WIDTH,
    parameter int unsigned DEPTH       = FETCH_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [WIDTH-1:0]       pc_i,
    output logic                   pc_advance_o,
    input  logic                   redirect_i,
    output logic                   imem_req_valid_o,
    input  logic                   imem_req_ready_i,
    output logic [WIDTH-1:0]       imem_req_addr_o,
    input  logic                   imem_rsp_valid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data_i,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [WIDTH-1:0]       instr_pc_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned EW = WIDTH + INSTR_WIDTH;

    logic [WIDTH-1:0] tag_head;
    logic [EW-1:0]    fq_head;
    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    occupancy;
    logic [CW-1:0]    drop_count;
    logic [CW-1:0]    drop_next;
    logic [CW:0]      in_use;
    logic             tag_full, tag_empty, fq_full, fq_empty;
    logic             req_valid, req_fire, rsp_take, instr_fire, rsp_consumed;

    // The tag queue holds exactly the outstanding requests, so its count is
    // the outstanding counter and flushing it zeroes outstanding.
    fetch_fifo #(
        .DATA_W (WIDTH),
        .DEPTH  (DEPTH)
    ) u_tag_q (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (redirect_i),
        .push_i  (req_fire),
        .data_i  (pc_i),
        .pop_i   (rsp_take),
        .data_o  (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .count_o (outstanding)
    );

    fetch_fifo #(
        .DATA_W (EW),
        .DEPTH  (DEPTH)
    ) u_instr_q (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (redirect_i),
        .push_i  (rsp_take),
        .data_i  ({tag_head, imem_rsp_data_i}),
        .pop_i   (instr_fire),
        .data_o  (fq_head),
        .full_o  (fq_full),
        .empty_o (fq_empty),
        .count_o (occupancy)
    );

    assign in_use = {1'b0, occupancy} + {1'b0, outstanding};

    // rst_ni gates the request so nothing is offered while reset is held.
    assign req_valid = rst_ni && !redirect_i && (in_use < (CW+1)'(DEPTH)) && (drop_count == '0);
    assign req_fire  = req_valid && imem_req_ready_i;

    // A response with nothing outstanding or pending drop is a protocol error and is ignored.
    assign rsp_take     = imem_rsp_valid_i && (drop_count == '0) && !tag_empty;
    assign rsp_consumed = imem_rsp_valid_i && ((drop_count != '0) || !tag_empty);
    assign instr_fire   = !fq_empty && instr_ready_i;

    assign imem_req_valid_o = req_valid;
    assign imem_req_addr_o  = pc_i;
    assign pc_advance_o     = req_fire;

    assign instr_valid_o = !fq_empty;
    assign instr_o       = fq_empty ? '0 : fq_head[INSTR_WIDTH-1:0];
    assign instr_pc_o    = fq_empty ? '0 : fq_head[EW-1:INSTR_WIDTH];

    // On redirect every in-flight response (new outstanding plus residual drops)
    // becomes a drop, less the one retiring this cycle.
    always_comb begin
        drop_next = drop_count;
        if (redirect_i) begin
            drop_next = drop_count + outstanding - CW'(rsp_consumed);
        end else if (imem_rsp_valid_i && (drop_count != '0)) begin
            drop_next = drop_count - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) drop_count <= '0;
        else         drop_count <= drop_next;
    end

    rsp_protocol_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        imem_rsp_valid_i |-> ((outstanding != '0) || (drop_count != '0)));

    credit_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (in_use + (CW+1)'(drop_count)) <= (CW+1)'(DEPTH));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int unsigned W = 32;
    localparam int unsigned DEPTH = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [W-1:0]  pc_i = '0;
    logic          pc_advance_o;
    logic          redirect_i = 1'b0;
    logic          imem_req_valid_o;
    logic          imem_req_ready_i = 1'b0;
    logic [W-1:0]  imem_req_addr_o;
    logic          imem_rsp_valid_i = 1'b0;
    logic [W-1:0]  imem_rsp_data_i = '0;
    logic          instr_valid_o;
    logic          instr_ready_i = 1'b0;
    logic [W-1:0]  instr_o;
    logic [W-1:0]  instr_pc_o;

    fetch_unit #(
        .WIDTH       (W),
        .INSTR_WIDTH (W),
        .DEPTH       (DEPTH)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .pc_i             (pc_i),
        .pc_advance_o     (pc_advance_o),
        .redirect_i       (redirect_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [W-1:0] data;
        int unsigned  due;
    } mem_rsp_t;

    // Reference model: what decode should see, what is in flight, what must be dropped.
    fetch_entry_t model_fq[$];
    logic [W-1:0] model_tags[$];
    int unsigned  model_drop;
    mem_rsp_t     mem_q[$];
    int unsigned  last_due;
    int unsigned  cyc;
    int unsigned  lat_lo, lat_hi;
    logic [W-1:0] pc;
    int unsigned  adv_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic         s_rv, s_adv, s_iv;
    logic [W-1:0] s_addr, s_instr, s_ipc;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] addr);
        if (addr == '0) return 32'hDEAD_BEEF;
        return addr * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    task automatic model_clear();
        model_fq.delete();
        model_tags.delete();
        mem_q.delete();
        model_drop = 0;
        last_due   = 0;
    endtask

    // One clock cycle: drive at the falling edge, sample and check 1 time unit later,
    // then advance the model to what the following rising edge must produce.
    task automatic step(input bit redir, input logic [W-1:0] tgt, input bit rq_rdy, input bit in_rdy);
        bit           rsp, exp_rv, exp_adv;
        logic [W-1:0] t;
        int unsigned  lat, due;
        @(negedge clk_i);
        cyc++;
        rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        redirect_i       = redir;
        pc_i             = redir ? tgt : pc;
        imem_req_ready_i = rq_rdy;
        instr_ready_i    = in_rdy;
        imem_rsp_valid_i = rsp;
        imem_rsp_data_i  = rsp ? mem_q[0].data : '0;
        #1;
        s_rv = imem_req_valid_o; s_adv = pc_advance_o; s_addr = imem_req_addr_o;
        s_iv = instr_valid_o;    s_instr = instr_o;    s_ipc = instr_pc_o;
        if (s_adv) adv_cnt++;

        exp_rv  = !redir && (model_fq.size() + model_tags.size() < DEPTH) && (model_drop == 0);
        exp_adv = exp_rv && rq_rdy;
        check_eq("req_valid", s_rv, exp_rv);
        check_eq("pc_advance", s_adv, exp_adv);
        if (exp_rv) check_eq("req_addr", s_addr, pc_i);
        check_eq("instr_valid", s_iv, model_fq.size() > 0);
        if (model_fq.size() > 0) begin
            check_eq("instr", s_instr, model_fq[0].instr);
            check_eq("instr_pc", s_ipc, model_fq[0].pc);
        end

        if (in_rdy && model_fq.size() > 0) void'(model_fq.pop_front());
        if (rsp) begin
            if (model_drop > 0) model_drop--;
            else if (model_tags.size() > 0) begin
                t = model_tags.pop_front();
                model_fq.push_back('{pc: t, instr: imem_rsp_data_i});
            end
        end
        if (exp_adv) model_tags.push_back(pc_i);
        if (redir) begin
            model_drop += model_tags.size();
            model_tags.delete();
            model_fq.delete();
        end

        // Instruction memory reacts to what the DUT actually issued.
        if (rsp) void'(mem_q.pop_front());
        if (s_rv && rq_rdy) begin
            lat = $urandom_range(lat_hi, lat_lo);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{data: mem_word(s_addr), due: due});
        end

        if (redir)      pc = tgt;
        else if (s_adv) pc = pc + 1;
    endtask

    task automatic hold_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        redirect_i = 1'b0; imem_rsp_valid_i = 1'b0;
        imem_req_ready_i = 1'b0; instr_ready_i = 1'b0;
        #1;
        check_eq("rst_instr_valid", instr_valid_o, 1'b0);
        check_eq("rst_req_valid", imem_req_valid_o, 1'b0);
        check_eq("rst_pc_advance", pc_advance_o, 1'b0);
        check_eq("rst_instr", instr_o, '0);
        model_clear();
        pc_i = pc;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        cyc = 0; adv_cnt = 0; lat_lo = 1; lat_hi = 1; pc = '0;
        model_clear();

        // Reset state and a single fetch returning 0xDEADBEEF for PC 0.
        hold_reset();
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);
        step(0, '0, 0, 1);
        check_eq("t1_adv_count", adv_cnt, 1);
        check_eq("t1_valid", s_iv, 1'b1);
        check_eq("t1_instr", s_instr, 32'hDEAD_BEEF);
        check_eq("t1_pc", s_ipc, 32'h0);

        // Decode stalled: credit limits fetch to DEPTH requests, then drains in order.
        adv_cnt = 0;
        repeat (6) step(0, '0, 1, 0);
        check_eq("t2_adv_count", adv_cnt, DEPTH);
        check_eq("t2_req_blocked", s_rv, 1'b0);
        step(0, '0, 0, 1);
        check_eq("t2_pop0_pc", s_ipc, 32'h1);
        step(0, '0, 0, 1);
        check_eq("t2_pop1_pc", s_ipc, 32'h2);
        check_eq("t2_resume_addr", s_addr, 32'h3);

        // Memory stall at 0x10: request held stable, one advance on accept.
        step(1, 32'h10, 0, 0);
        adv_cnt = 0;
        repeat (3) begin
            step(0, '0, 0, 0);
            check_eq("t3_addr_stable", s_addr, 32'h10);
        end
        check_eq("t3_no_adv", adv_cnt, 0);
        lat_lo = 3; lat_hi = 3;
        step(0, '0, 1, 0);
        check_eq("t3_one_adv", adv_cnt, 1);

        // Redirect with two outstanding: both responses dropped, fetch restarts at 0x100.
        step(0, '0, 1, 0);
        step(1, 32'h100, 0, 1);
        repeat (5) begin
            step(0, '0, 0, 1);
            check_eq("t4_no_stale", s_iv, 1'b0);
        end
        check_eq("t4_req_valid", s_rv, 1'b1);
        check_eq("t4_new_addr", s_addr, 32'h100);

        // Randomised traffic: redirects collide with responses, stalls on both sides.
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 3000; i++) begin
            if (i == 2000) lat_hi = 1;
            step($urandom_range(15, 0) == 0, $urandom, $urandom_range(3, 0) != 0,
                 (i % 500 < 100) ? ($urandom_range(3, 0) == 0) : ($urandom_range(3, 0) != 0));
        end

        // Reset while the queue is full, then a clean restart.
        lat_lo = 1; lat_hi = 2;
        repeat (8) step(0, '0, 1, 0);
        check_eq("t6_full_before", s_iv, 1'b1);
        pc = 32'h40;
        hold_reset();
        step(0, '0, 1, 1);
        check_eq("t6_restart_valid", s_rv, 1'b1);
        check_eq("t6_restart_addr", s_addr, 32'h40);
        check_eq("t6_no_stale", s_iv, 1'b0);
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(20, 0) == 0, $urandom, $urandom_range(1, 0) != 0, $urandom_range(3, 0) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
